descrambler_sync: RTL and testbench

- Receive-side counterpart of the team's serial self-synchronizing scrambler, whose transmit rule is tx = data ^ fb, with the state shifting in tx.
- Recovers the payload bit stream from the scrambled serial line: data = rx ^ fb, with the state shifting in rx.
- Includes a sync monitor that declares lock after a run of idle bits and drops lock on an excessive error rate.
- Sits between the serial deserializer/sampler and the link-layer framer.

---
 rtl/descrambler_sync.sv | 143 ++++++++++++++
 tb/tb_descrambler_sync.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_sync.sv
// Self-synchronizing serial descrambler with an idle-pattern sync monitor.
// Recovers data = rx ^ fb and tracks lock/loss-of-lock from the idle stream.
module descrambler_sync #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = {1'b1, {(WIDTH-1){1'b0}}},
    parameter logic             IDLE_BIT = 1'b1,
    parameter int               LOCK_CNT = 16,
    parameter int               WINDOW   = 64,
    parameter int               ERR_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic        rx_bit,
    input  logic        clr_err,
    output logic        data_valid,
    output logic        data_bit,
    output logic        locked,
    output logic        lock_lost,
    output logic [15:0] err_count
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int RUN_W  = 8;
    localparam int WIN_W  = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        FILL,
        SEARCH,
        LOCKED
    } mon_state_t;

    mon_state_t        mon_q, mon_d;
    logic [WIDTH-1:0]  shift_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_pos_q, win_pos_d;
    logic [WIN_W-1:0]  win_err_q, win_err_d;
    logic [15:0]       err_d;
    logic              fb;
    logic              desc_bit;
    logic              is_err;
    logic              lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_q      <= FILL;
            shift_q    <= '0;
            fill_q     <= '0;
            run_q      <= '0;
            win_pos_q  <= '0;
            win_err_q  <= '0;
            err_count  <= '0;
            lock_lost  <= 1'b0;
            data_valid <= 1'b0;
            data_bit   <= 1'b0;
        end else begin
            mon_q      <= mon_d;
            fill_q     <= fill_d;
            run_q      <= run_d;
            win_pos_q  <= win_pos_d;
            win_err_q  <= win_err_d;
            err_count  <= err_d;
            lock_lost  <= lost;
            data_valid <= rx_valid && (mon_q != FILL);
            if (rx_valid) begin
                shift_q  <= {shift_q[WIDTH-2:0], rx_bit};
                data_bit <= desc_bit;
            end
        end
    end

    // Loss of lock is checked before window rollover so an ERR_MAX-th error
    // on the last window bit still drops lock.
    always_comb begin
        fb        = ^(shift_q & TAPS);
        desc_bit  = rx_bit ^ fb;
        mon_d     = mon_q;
        fill_d    = fill_q;
        run_d     = run_q;
        win_pos_d = win_pos_q;
        win_err_d = win_err_q;
        is_err    = 1'b0;
        lost      = 1'b0;

        if (rx_valid) begin
            case (mon_q)
                FILL: begin
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        mon_d  = SEARCH;
                        fill_d = '0;
                        run_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                SEARCH: begin
                    if (desc_bit == IDLE_BIT) begin
                        if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                            mon_d     = LOCKED;
                            run_d     = '0;
                            win_pos_d = '0;
                            win_err_d = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    is_err = (desc_bit != IDLE_BIT);
                    if (is_err && (win_err_q == WIN_W'(ERR_MAX - 1))) begin
                        mon_d     = SEARCH;
                        run_d     = '0;
                        win_pos_d = '0;
                        win_err_d = '0;
                        lost      = 1'b1;
                    end else if (win_pos_q == WIN_W'(WINDOW - 1)) begin
                        win_pos_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_pos_d = win_pos_q + 1'b1;
                        win_err_d = win_err_q + WIN_W'(is_err);
                    end
                end
                default: mon_d = FILL;
            endcase
        end
    end

    always_comb begin
        err_d = err_count;
        if (clr_err) begin
            err_d = is_err ? 16'd1 : 16'd0;
        end else if (is_err && (err_count != 16'hFFFF)) begin
            err_d = err_count + 16'd1;
        end
    end

    assign locked = (mon_q == LOCKED);

endmodule

// File: tb/tb_descrambler_sync.sv
// Directed table-driven bench for descrambler_sync plus hand-written
// sequences for error windows, relock, mid-stream reset and saturation.
module tb_descrambler_sync;

    logic        clk = 1'b0;
    logic        rst, rx_valid, rx_bit, clr_err;
    logic        data_valid, data_bit, locked, lock_lost;
    logic [15:0] err_count;

    logic        s_rst, s_valid, s_bit, s_clr;
    logic        s_dv, s_db, s_lk, s_ll;
    logic [15:0] s_err;

    always #5 clk = ~clk;

    descrambler_sync dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_bit    (rx_bit),
        .clr_err   (clr_err),
        .data_valid(data_valid),
        .data_bit  (data_bit),
        .locked    (locked),
        .lock_lost (lock_lost),
        .err_count (err_count)
    );

    // Wide window and single-bit lock so err_count can be driven to saturation quickly.
    descrambler_sync #(
        .WIDTH(4), .TAPS(4'b1000), .IDLE_BIT(1'b1),
        .LOCK_CNT(1), .WINDOW(1024), .ERR_MAX(1024)
    ) sat (
        .clk       (clk),
        .rst       (s_rst),
        .rx_valid  (s_valid),
        .rx_bit    (s_bit),
        .clr_err   (s_clr),
        .data_valid(s_dv),
        .data_bit  (s_db),
        .locked    (s_lk),
        .lock_lost (s_ll),
        .err_count (s_err)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic        flip;
        logic        clr;
        logic [19:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          applied     = 0;
    int          miscompares = 0;
    int          phase       = 0;
    logic [7:0]  pat         = 8'b0000_1111;
    logic [3:0]  tx_hist     = 4'b0000;

    localparam logic [19:0] MASK_ALL   = 20'hFFFFF;
    localparam logic [19:0] MASK_NO_DB = 20'hBFFFF;
    localparam logic [19:0] MASK_MON   = 20'h3FFFF;

    function automatic logic [19:0] pack(input logic dv, input logic db, input logic lk,
                                         input logic ll, input logic [15:0] err);
        return {dv, db, lk, ll, err};
    endfunction

    function automatic void addVec(input logic r, input logic v, input logic [19:0] exp);
        vec_t t;
        t.r    = r;
        t.v    = v;
        t.flip = 1'b0;
        t.clr  = 1'b0;
        t.exp  = exp;
        vecs.push_back(t);
    endfunction

    // Line bits come from the all-ones scrambled pattern 1,1,1,1,0,0,0,0.
    task automatic applyStimulus(input logic r, input logic v, input logic flip, input logic clr);
        rst      = r;
        rx_valid = v;
        rx_bit   = pat[phase] ^ flip;
        clr_err  = clr;
        if (v) phase = (phase + 1) % 8;
        @(posedge clk);
        #1;
    endtask

    // Transmit-side scrambler for the saturation instance: tx = d ^ fb.
    task automatic applySatStimulus(input logic r, input logic v, input logic d, input logic clr);
        logic tx;
        tx      = d ^ tx_hist[3];
        s_rst   = r;
        s_valid = v;
        s_bit   = tx;
        s_clr   = clr;
        if (v) tx_hist = {tx_hist[2:0], tx};
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [19:0] act,
                               input logic [19:0] exp, input logic [19:0] mask);
        applied++;
        if ((act & mask) !== (exp & mask)) begin
            miscompares++;
            $display("[TB] FAIL %s: got {dv,db,lk,ll,err}=%h, expected %h (care mask %h)",
                     name, act, exp, mask);
        end
    endtask

    function automatic logic [19:0] mainOut();
        return {data_valid, data_bit, locked, lock_lost, err_count};
    endfunction

    function automatic logic [19:0] satOut();
        return {s_dv, s_db, s_lk, s_ll, s_err};
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] cnt;
        logic        fl, er, cnted;

        rst = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0; clr_err = 1'b0;
        s_rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_clr = 1'b0;

        // Reset, continuous stream to lock, reset, half-rate stream to lock.
        addVec(1'b1, 1'b0, pack(0, 0, 0, 0, 16'd0));
        for (int i = 0; i < 24; i++)
            addVec(1'b0, 1'b1, pack(i >= 4, 1'b1, i >= 19, 1'b0, 16'd0));
        addVec(1'b1, 1'b0, pack(0, 0, 0, 0, 16'd0));
        for (int j = 0; j < 44; j++)
            addVec(1'b0, (j % 2) == 0,
                   pack(((j % 2) == 0) && ((j / 2) >= 4), 1'b1, (j / 2) >= 19, 1'b0, 16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].r) phase = 0;
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].flip, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), mainOut(), vecs[i].exp, MASK_ALL);
        end

        // Reset mid-lock without restarting the line: fill is redone.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset", mainOut(), pack(0, 0, 0, 0, 16'd0), MASK_ALL);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("refill%0d", i), mainOut(), pack(0, 0, 0, 0, 16'd0), MASK_NO_DB);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("relock%0d", i), mainOut(), pack(1, 1, i == 15, 0, 16'd0), MASK_ALL);
        end

        // Errors straddling a window boundary, then 4 errors in one window.
        cnt = 16'd0;
        for (int n = 1; n <= 91; n++) begin
            fl    = (n == 1) || (n == 62) || (n == 70) || (n == 71);
            er    = (n == 1) || (n == 5) || (n == 62) || (n == 66) ||
                    (n == 70) || (n == 71) || (n == 74) || (n == 75);
            cnted = er && (n != 75);
            if (cnted) cnt = cnt + 16'd1;
            applyStimulus(1'b0, 1'b1, fl, 1'b0);
            checkOutput($sformatf("win1_n%0d", n), mainOut(),
                        pack(1, !er, (n < 74) || (n == 91), n == 74, cnt), MASK_ALL);
        end

        // ERR_MAX-th error lands on the last bit of the window.
        for (int m = 1; m <= 65; m++) begin
            fl = (m == 1) || (m == 60);
            er = (m == 1) || (m == 5) || (m == 60) || (m == 64);
            if (er) cnt = cnt + 16'd1;
            applyStimulus(1'b0, 1'b1, fl, 1'b0);
            checkOutput($sformatf("win2_m%0d", m), mainOut(),
                        pack(1, !er, m < 64, m == 64, cnt), MASK_ALL);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation: rounds of one idle (lock) then 1024 errors (loss).
        applySatStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("sat_reset", satOut(), pack(0, 0, 0, 0, 16'd0), MASK_ALL);
        for (int i = 0; i < 4; i++) applySatStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int r = 0; r < 63; r++) begin
            applySatStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 1024; k++) applySatStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (r == 0)
                checkOutput("sat_round0", satOut(), pack(0, 0, 0, 1, 16'd1024), MASK_MON);
        end
        checkOutput("sat_63rounds", satOut(), pack(0, 0, 0, 1, 16'hFC00), MASK_MON);
        applySatStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 1022; k++) applySatStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_fffe", satOut(), pack(1, 0, 1, 0, 16'hFFFE), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_ffff", satOut(), pack(1, 0, 1, 0, 16'hFFFF), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_hold_loss", satOut(), pack(1, 0, 0, 1, 16'hFFFF), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("sat_relock", satOut(), pack(1, 1, 1, 0, 16'hFFFF), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_hold", satOut(), pack(1, 0, 1, 0, 16'hFFFF), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_with_err", satOut(), pack(1, 0, 1, 0, 16'd1), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_idle", satOut(), pack(1, 1, 1, 0, 16'd0), MASK_ALL);
        applySatStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("err_after_clr", satOut(), pack(1, 0, 1, 0, 16'd1), MASK_ALL);
        applySatStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_no_valid", satOut(), pack(0, 0, 1, 0, 16'd0), MASK_ALL);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
